// File: rtl/fft32_twiddle_mul.sv
// Complex sample x twiddle multiplier for a 32-point FFT stage.
// Three-stage pipeline (ROM wait, multiply, round/saturate) sharing a single advance enable.
module fft32_twiddle_mul #(
    parameter int DW  = 16,
    parameter int TWW = 18
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [DW-1:0]  in_re,
    input  logic signed [DW-1:0]  in_im,
    input  logic                  in_last,
    input  logic [4:0]            tw_step,
    output logic [4:0]            tw_addr,
    input  logic signed [TWW-1:0] tw_re,
    input  logic signed [TWW-1:0] tw_im,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [DW-1:0]  out_re,
    output logic signed [DW-1:0]  out_im,
    output logic                  out_last,
    output logic                  sat_flag
);

    localparam int PW = DW + TWW + 1;
    localparam int RW = PW - 10;
    localparam logic signed [RW-1:0] MAX_R = RW'((2 ** (DW - 1)) - 1);
    localparam logic signed [RW-1:0] MIN_R = RW'(-(2 ** (DW - 1)));

    // Round half up on 10 fractional twiddle bits.
    function automatic logic signed [RW-1:0] rnd(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] t;
        t = p + PW'(512);
        return RW'(t >>> 10);
    endfunction

    function automatic logic is_sat(input logic signed [RW-1:0] r);
        return (r > MAX_R) || (r < MIN_R);
    endfunction

    function automatic logic signed [DW-1:0] clip(input logic signed [RW-1:0] r);
        if (r > MAX_R) return MAX_R[DW-1:0];
        if (r < MIN_R) return MIN_R[DW-1:0];
        return r[DW-1:0];
    endfunction

    logic       adv, accept;
    logic       frame_start;
    logic [4:0] phase, step_q, step_sel, idx_p1;
    logic       vld_p1, vld_p2;

    logic signed [DW-1:0] re_p1, im_p1;
    logic                 last_p1, last_p2;
    logic signed [PW-1:0] pr_p2, pi_p2;

    logic signed [PW-1:0] a_re, a_im, b_re, b_im, pr_nx, pi_nx;
    logic signed [RW-1:0] rnd_re, rnd_im;

    assign adv      = ~out_valid | out_ready;
    assign accept   = in_valid & adv;
    assign in_ready = adv;
    assign step_sel = frame_start ? tw_step : step_q;
    // While stalled, keep re-addressing S1's index so the registered ROM stays aligned with it.
    assign tw_addr  = adv ? phase : idx_p1;

    always_comb begin
        a_re   = PW'(re_p1);
        a_im   = PW'(im_p1);
        b_re   = PW'(tw_re);
        b_im   = PW'(tw_im);
        pr_nx  = a_re * b_re - a_im * b_im;
        pi_nx  = a_re * b_im + a_im * b_re;
        rnd_re = rnd(pr_p2);
        rnd_im = rnd(pi_p2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase       <= '0;
            step_q      <= '0;
            frame_start <= 1'b1;
        end else if (accept) begin
            if (frame_start) step_q <= tw_step;
            if (in_last) begin
                phase       <= '0;
                frame_start <= 1'b1;
            end else begin
                phase       <= phase + step_sel;
                frame_start <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            idx_p1    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            sat_flag  <= 1'b0;
        end else if (adv) begin
            vld_p1    <= accept;
            idx_p1    <= phase;
            vld_p2    <= vld_p1;
            out_valid <= vld_p2;
            out_last  <= vld_p2 & last_p2;
            out_re    <= clip(rnd_re);
            out_im    <= clip(rnd_im);
            if (vld_p2 && (is_sat(rnd_re) || is_sat(rnd_im))) sat_flag <= 1'b1;
        end
    end

    // S1 sample capture / S2 full-precision products
    always_ff @(posedge clk) begin
        if (adv) begin
            re_p1   <= in_re;
            im_p1   <= in_im;
            last_p1 <= in_last;
            pr_p2   <= pr_nx;
            pi_p2   <= pi_nx;
            last_p2 <= last_p1;
        end
    end

endmodule

// File: tb/tb_fft32_twiddle_mul.sv
// Bench for fft32_twiddle_mul: registered W32 ROM model, frame/index model and output scoreboard.
module tb_fft32_twiddle_mul;

    localparam int DW  = 16;
    localparam int TWW = 18;
    localparam real PI = 3.14159265358979323846;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  in_valid, in_ready, in_last;
    logic signed [DW-1:0]  in_re, in_im, out_re, out_im;
    logic [4:0]            tw_step, tw_addr;
    logic signed [TWW-1:0] tw_re, tw_im;
    logic                  out_valid, out_ready, out_last, sat_flag;

    int  rom_re[32], rom_im[32];
    int  n_tests = 0, n_fail = 0;
    int  exp_re_q[$], exp_im_q[$];
    bit  exp_last_q[$];
    int  got_re[$], got_im[$];
    bit  got_last[$];
    int  addr_log[$];
    bit  m_fs = 1'b1;
    int  m_k = 0, m_step = 0;
    bit  bp = 1'b0;
    bit  stall_prev = 1'b0;
    logic [2*DW+1:0] held;

    fft32_twiddle_mul #(.DW(DW), .TWW(TWW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im), .in_last(in_last),
        .tw_step(tw_step), .tw_addr(tw_addr),
        .tw_re(tw_re), .tw_im(tw_im),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .out_last(out_last),
        .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    initial begin
        for (int n = 0; n < 32; n++) begin
            rom_re[n] = int'($floor(1024.0 * $cos(2.0 * PI * n / 32.0) + 1.0e-6));
            rom_im[n] = int'($floor(-1024.0 * $sin(2.0 * PI * n / 32.0) + 1.0e-6));
        end
    end

    // Registered twiddle ROM: data one clock after the address
    always @(posedge clk) begin
        tw_re <= TWW'(rom_re[tw_addr]);
        tw_im <= TWW'(rom_im[tw_addr]);
    end

    function automatic void chk(input string name, input longint act, input longint req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endfunction

    function automatic int mq(input longint p);
        longint r;
        r = (p + 512) >>> 10;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return int'(r);
    endfunction

    function automatic int m_re(input int re, input int im, input int n);
        return mq(longint'(re) * rom_re[n] - longint'(im) * rom_im[n]);
    endfunction

    function automatic int m_im(input int re, input int im, input int n);
        return mq(longint'(re) * rom_im[n] + longint'(im) * rom_re[n]);
    endfunction

    always @(negedge clk) begin
        int idx, er, ei;
        bit el;
        if (!rst_n) begin
            exp_re_q.delete(); exp_im_q.delete(); exp_last_q.delete();
            m_fs = 1'b1; m_k = 0; stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                chk("hold_stable", longint'({out_valid, out_last, out_re, out_im}), longint'(held));
            if (out_valid && out_ready) begin
                if (exp_re_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    er = exp_re_q.pop_front();
                    ei = exp_im_q.pop_front();
                    el = exp_last_q.pop_front();
                    chk("out_re", longint'(out_re), longint'(er));
                    chk("out_im", longint'(out_im), longint'(ei));
                    chk("out_last", longint'(out_last), longint'(el));
                    got_re.push_back(int'(out_re));
                    got_im.push_back(int'(out_im));
                    got_last.push_back(out_last);
                end
            end
            stall_prev = out_valid && !out_ready;
            held = {out_valid, out_last, out_re, out_im};
            if (in_valid && in_ready) begin
                if (m_fs) begin
                    m_step = int'(tw_step);
                    m_k = 0;
                end
                idx = (m_k * m_step) % 32;
                chk("tw_addr", longint'(tw_addr), longint'(idx));
                addr_log.push_back(int'(tw_addr));
                exp_re_q.push_back(m_re(int'(in_re), int'(in_im), idx));
                exp_im_q.push_back(m_im(int'(in_re), int'(in_im), idx));
                exp_last_q.push_back(in_last);
                if (in_last) m_fs = 1'b1;
                else begin
                    m_fs = 1'b0;
                    m_k++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send(input int re, input int im, input bit last, input int step, input bit gaps);
        int t;
        if (gaps && $urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
        in_re = DW'(re);
        in_im = DW'(im);
        in_last = last;
        tw_step = 5'(step);
        in_valid = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 200) begin
                $display("FAIL send_timeout: in_ready stuck at 0 for %0d cycles, expected 1", t);
                $fatal(1);
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_re_q.size() != 0 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        chk("drain_pending", longint'(exp_re_q.size()), 0);
    endtask

    task automatic clear_logs();
        got_re.delete(); got_im.delete(); got_last.delete(); addr_log.delete();
    endtask

    initial begin
        time t0;
        rst_n = 1'b0; in_valid = 1'b0; in_re = '0; in_im = '0; in_last = 1'b0;
        tw_step = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid_low", longint'(out_valid), 0);
        rst_n = 1'b1;
        chk("rst_in_ready", longint'(in_ready), 1);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_last", longint'(out_last), 0);
        chk("rst_sat_flag", longint'(sat_flag), 0);
        chk("rst_tw_addr", longint'(tw_addr), 0);

        // Latency: single-sample frame
        send(100, -50, 1'b1, 0, 1'b0);
        chk("lat_c1", longint'(out_valid), 0);
        @(posedge clk); #1;
        chk("lat_c2", longint'(out_valid), 0);
        @(posedge clk); #1;
        chk("lat_c3", longint'(out_valid), 1);
        chk("lat_re", longint'(out_re), 100);
        chk("lat_im", longint'(out_im), -50);
        drain();

        // Identity, sustained throughput
        clear_logs();
        t0 = $time;
        for (int k = 0; k < 32; k++) send(k, -k, k == 31, 0, 1'b0);
        chk("id_throughput_cycles", longint'(($time - t0) / 10), 32);
        drain();
        chk("id_count", longint'(got_re.size()), 32);
        chk("id_re31", longint'(got_re[31]), 31);
        chk("id_im31", longint'(got_im[31]), -31);
        chk("id_im5", longint'(got_im[5]), -5);
        chk("id_last31", longint'(got_last[31]), 1);
        chk("id_last30", longint'(got_last[30]), 0);

        // Rotation by W32^8
        clear_logs();
        for (int k = 0; k < 32; k++) send(k == 8 ? 1000 : 0, 0, k == 31, 1, 1'b0);
        drain();
        chk("rot_addr8", longint'(addr_log[8]), 8);
        chk("rot_re8", longint'(got_re[8]), 0);
        chk("rot_im8", longint'(got_im[8]), -1000);

        // Saturation
        chk("sat_pre", longint'(sat_flag), 0);
        clear_logs();
        for (int k = 0; k < 8; k++)
            send(k == 4 ? 32767 : k * 10, k == 4 ? 32767 : 0, k == 7, 1, 1'b0);
        drain();
        chk("sat_re4", longint'(got_re[4]), 32767);
        chk("sat_im4", longint'(got_im[4]), -32);
        chk("sat_flag_set", longint'(sat_flag), 1);
        for (int k = 0; k < 4; k++) send(k, k, k == 3, 0, 1'b0);
        drain();
        chk("sat_flag_sticky", longint'(sat_flag), 1);

        // Wrap and step latch: step changes mid-frame
        clear_logs();
        for (int k = 0; k < 32; k++) send(k * 7 - 100, 50 - k, k == 31, k < 10 ? 3 : 5, 1'b0);
        for (int k = 0; k < 4; k++) send(k, 1, k == 3, 5, 1'b0);
        drain();
        chk("wrap_addr10", longint'(addr_log[10]), 30);
        chk("wrap_addr11", longint'(addr_log[11]), 1);
        chk("wrap_addr31", longint'(addr_log[31]), 29);
        chk("next_frame_addr1", longint'(addr_log[33]), 5);

        // Backpressure with input gaps and tw_step churn
        clear_logs();
        bp = 1'b1;
        for (int k = 0; k < 64; k++)
            send(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
                 (k % 32) == 31, int'($urandom_range(0, 31)), 1'b1);
        drain();
        bp = 1'b0;
        @(posedge clk); #1;
        chk("bp_count", longint'(got_re.size()), 64);

        // Reset mid-frame
        for (int k = 0; k < 13; k++) send(k * 100, k, 1'b0, 1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", longint'(out_valid), 0);
        chk("midrst_sat_flag", longint'(sat_flag), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_logs();
        chk("midrst_release_ready", longint'(in_ready), 1);
        chk("midrst_release_valid", longint'(out_valid), 0);
        for (int k = 0; k < 4; k++) send(k + 1, k, k == 3, 2, 1'b0);
        drain();
        chk("midrst_addr0", longint'(addr_log[0]), 0);
        chk("midrst_addr1", longint'(addr_log[1]), 2);
        chk("midrst_count", longint'(got_re.size()), 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fft32_twiddle_mul.md
FFT32_TWIDDLE_MUL -- requirements
Module: fft32_twiddle_mul

Interface
REQ-001 SHALL have parameter DW, default 16: data sample width (signed, per I/Q component).
REQ-002 SHALL have parameter TWW, default 18: twiddle width (signed, 1.0 = 1024, i.e. 10 fractional bits).
REQ-003 SHALL have ports:
- clk  in  1: master clock, all state on rising edge.
- rst_n  in  1: reset, asynchronous, active-low.
- in_valid  in  1: input sample valid.
- in_ready  out  1: block can accept a sample this cycle.
- in_re, in_im  in  DW: input sample, signed.
- in_last  in  1: marks the last sample of a frame.
- tw_step  in  5: twiddle index increment per sample; latched at frame start.
- tw_addr  out  5: address to the 32-entry registered twiddle ROM (W32^n).
- tw_re, tw_im  in  TWW: ROM data, valid one clock after tw_addr.
- out_valid  out  1: output sample valid.
- out_ready  in  1: downstream accepts output.
- out_re, out_im  out  DW: product sample, signed.
- out_last  out  1: in_last delayed with its sample.
- sat_flag  out  1: sticky; set when any output component saturated.

Function
REQ-004 SHALL define accept = in_valid & in_ready and adv = ~out_valid | out_ready.
REQ-005 SHALL drive in_ready = adv; the three pipeline stages (S1 ROM wait, S2 multiply, S3 output) all advance only when adv=1.
REQ-006 SHALL keep a 5-bit phase register; the twiddle index of an accepted sample is the phase at acceptance.
REQ-007 SHALL latch tw_step into step_q on acceptance of the first sample of a frame (first sample after reset or after an accepted in_last); for that sample phase is 0.
REQ-008 SHALL, on accept without in_last, update phase <= (phase + step) mod 32, where step = tw_step for a frame's first sample and step_q otherwise; wrap past 31 is silent.
REQ-009 SHALL, on accept with in_last, set phase <= 0 and mark the next sample as frame start.
REQ-010 SHALL drive tw_addr = phase when adv=1, and the index held in S1 when adv=0, so ROM output stays aligned with S1 during stalls.
REQ-011 SHALL register in S2: pr = in_re*tw_re - in_im*tw_im and pi = in_re*tw_im + in_im*tw_re at full precision (DW+TWW+1 bits).
REQ-012 SHALL round in S3 as (p + 512) >>> 10 (arithmetic shift), then saturate to [-2^(DW-1), 2^(DW-1)-1].
REQ-013 SHALL set sat_flag when a saturated sample is loaded into S3; it is cleared only by reset.
REQ-014 SHALL give latency 3 cycles from accept to out_valid with no stall; one result per cycle sustained when out_ready=1.
REQ-015 SHALL hold out_re, out_im, out_last, out_valid stable while out_valid=1 and out_ready=0.
REQ-016 SHALL allow bubbles (in_valid=0) anywhere; phase and step_q do not change on non-accept cycles.
REQ-017 SHALL tolerate tw_step changing mid-frame without effect until the next frame start.

Reset
REQ-018 SHALL on rst_n=0 asynchronously clear: all stage valids, out_valid, out_last, out_re, out_im, sat_flag, phase, step_q, tw_addr-related state; frame-start flag set.
REQ-019 SHALL discard in-flight samples on reset mid-frame; first accept after reset uses phase 0 and the current tw_step.
REQ-020 SHALL show in_ready=1 in the first cycle after reset release.

Verification
REQ-021 Identity: tw_step=0, 32 samples in_re=k, in_im=-k, out_ready=1 -> outputs equal inputs, out_valid 3 cycles after each accept, out_last on sample 31.
REQ-022 Rotation: tw_step=1, sample 8 = 1000+0j, ROM model W32 -> tw_addr=8, output 0-1000j exactly.
REQ-023 Saturation: tw_step=1, sample 4 = 32767+32767j (tw 724,-725) -> out_re=32767, out_im=-32, sat_flag=1 and stays 1.
REQ-024 Wrap/latch: tw_step=3 at frame start, changed to 5 mid-frame -> tw_addr sequence 0,3,6,...,30,1,4,... for all 32 samples; next frame uses 5.
REQ-025 Backpressure: random out_ready at 50%, random in_valid gaps -> output stream bit-exact against golden model, no loss/duplication, outputs stable while stalled.
REQ-026 Reset mid-frame: rst_n low for 2 cycles at sample 13 -> out_valid=0 immediately, no stale outputs after release, next frame starts at tw_addr=0.
